ring_scan_display_driver: RTL
=============================

# ring_scan_display_driver

Consumes the 4-bit one-hot phase produced by the ring counter and uses it to scan a 4-digit multiplexed 7-segment display. Digit data arrives through a valid/ready write port and is double-buffered so that a scan rotation never shows a mix of old and new digits. The block checks every phase it receives for one-hot legality and correct rotation order. Repeated phase errors put it into a sticky fault state that blanks the display.

## Interface
Parameters:
- SEG_ACTIVE_LOW, 0: when 1, `seg` and `an` are inverted at the output pins. Internal logic is unchanged.
- FAULT_LIMIT, 3: number of consecutive bad phases (range 1..15) that forces FAULT.

Ports:
- clk  in  1  single clock; rising edge.
- clear  in  1  reset, asynchronous and active-high.
- phase  in  4  one-hot ring phase as {ff1,ff2,ff3,ff4}. Legal order: 1000→0100→0010→0001→1000.
- wr_valid  in  1  write request.
- wr_data  in  16  four BCD nibbles. [15:12] is digit 0 (phase 1000); [3:0] is digit 3 (phase 0001).
- wr_ready  out  1  write can be accepted.
- fault_clr  in  1  one-cycle pulse; leaves FAULT.
- an  out  4  digit enables. Mirrors the accepted phase; active-high before polarity.
- seg  out  7  segments {a,b,c,d,e,f,g}; active-high before polarity.
- rotations  out  8  count of completed rotations; wraps 255→0.
- fault  out  1  high while in FAULT.

## Operation
- States: SYNC, RUN, FAULT. Reset state is SYNC.
- Reset values (logical, before polarity): an=0000, seg=0000000, wr_ready=1, rotations=0, fault=0, active and shadow buffers=0, shadow_pending=0, bad_cnt=0, prev_phase=0000.
- SYNC: display blank. On the first sampled phase==1000, go to RUN. On that same edge, digit 0 is driven and prev_phase is set to 1000.
- RUN: a phase is good when it is one-hot AND either equals prev_phase (hold) or is prev_phase rotated right by one.
  - Good phase: an<=phase, seg<=decode(nibble selected by phase), bad_cnt<=0, prev_phase<=phase.
  - Bad phase (0000, multi-hot, or out of order): an<=0000, seg<=0, bad_cnt increments, prev_phase is unchanged.
  - When bad_cnt would reach FAULT_LIMIT: go to FAULT.
- FAULT: display blank, fault=1. Phase is ignored. A fault_clr pulse goes to SYNC on the next edge and clears bad_cnt and fault. rotations is held.
- Rotation count: rotations increments on a good 0001→1000 step in RUN only. A hold at 1000 does not count.
- Write port:
  - A write is accepted on an edge where wr_valid && wr_ready. wr_data goes to the shadow buffer and shadow_pending is set.
  - wr_ready = !shadow_pending (combinational).
  - Shadow-to-active transfer happens:
    - in RUN, on a good step into 1000 (including the SYNC→RUN entry);
    - in SYNC or FAULT, on the edge after acceptance.
  - The transfer clears shadow_pending. A nibble being displayed on the transfer edge uses the new data.
- Decode: values 0-9 use standard segment patterns. Values 10-15 blank the digit unless the Configuration macro is defined.
- A mid-operation `clear` acts immediately, whatever the state: all outputs go to their reset values, and any pending shadow data is lost.

## Timing
- Phase-to-display latency is 1 cycle: phase sampled at edge k gives an/seg/state valid after edge k.
- Write-to-display latency: the next legal 1000 entry in RUN, or 2 edges from acceptance in SYNC/FAULT.
- The earliest back-to-back write is one cycle after the transfer edge.
- wr_ready is low from the acceptance edge until the transfer edge.
- fault rises after the edge that samples the FAULT_LIMIT-th consecutive bad phase.
- fault_clr has priority over any phase input while in FAULT.
- No other input is required to be stable beyond normal setup and hold.

## Configuration
- RING_SCAN_HEX_EN:
  - Defined: nibbles 10-15 display as A, b, C, d, E, F.
  - Undefined: nibbles 10-15 blank the digit (seg=0) while `an` is still driven.
- No other behaviour changes.

## Test plan
- Clean rotation: release clear, load wr_data=16'h1234, drive phase 1000,0100,0010,0001 repeatedly → an follows phase one cycle later, seg shows 1,2,3,4, rotations=2 after the 2nd return to 1000.
- Tear-free update: write 16'h5678 while phase=0100 → digits 3 and 4 keep showing for the rest of the rotation, 5 appears only at the next 1000, wr_ready is low until then.
- Bad phase recovery: in RUN drive 0110 once, then 0010 (legal after 0100) → one blank cycle, bad_cnt returns to 0, fault stays 0.
- Fault and clear: with FAULT_LIMIT=3, drive 0000 three times → fault=1, display blank; pulse fault_clr, then drive 1000 → SYNC then RUN, rotations unchanged.
- Hex option: load 16'hABCF → blank digits without RING_SCAN_HEX_EN; with it defined, shows A, b, C, F.
- Async reset mid-write: assert clear while shadow_pending=1 → wr_ready=1, an=0000, rotations=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ring_scan_display_driver_if.sv
// Digit write port for ring_scan_display_driver.
// Carries one 16-bit word of four BCD nibbles under a valid/ready handshake.
interface ring_scan_display_driver_if;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/ring_scan_display_driver.sv
// Scans a 4-digit multiplexed 7-segment display from a one-hot ring phase, with double-buffered digits.
// Optional macro RING_SCAN_HEX_EN: show nibbles 10-15 as A,b,C,d,E,F instead of blanking them.
module ring_scan_display_driver #(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int FAULT_LIMIT    = 3
) (
  input  logic                             clk,
  input  logic                             clear,
  input  logic [3:0]                       phase,
  ring_scan_display_driver_if.slave        wr,
  input  logic                             fault_clr,
  output logic [3:0]                       an,
  output logic [6:0]                       seg,
  output logic [7:0]                       rotations,
  output logic                             fault
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [3:0] BAD_LIMIT = 4'(FAULT_LIMIT);
  localparam logic [3:0] PH_FIRST  = 4'b1000;
  localparam logic [3:0] PH_LAST   = 4'b0001;

  state_t      state_reg;
  logic [3:0]  an_reg;
  logic [6:0]  seg_reg;
  logic [7:0]  rotations_reg;
  logic        fault_reg;
  logic [15:0] active_reg;
  logic [15:0] shadow_reg;
  logic        shadow_pending_reg;
  logic [3:0]  bad_cnt_reg;
  logic [3:0]  prev_phase_reg;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
`ifdef RING_SCAN_HEX_EN
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
`endif
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic        accept;
  logic        phase_good;
  logic        wrap_step;
  logic        xfer;
  logic [15:0] disp_data;
  logic [3:0]  nibble;
  logic [6:0]  seg_next;
  logic [3:0]  bad_cnt_next;
  logic [3:0]  sel_nib [4];

  assign wr.wr_ready = !shadow_pending_reg;
  assign accept      = wr.wr_valid && !shadow_pending_reg;

  // Good = one-hot and either a hold or one rotate-right step from the last accepted phase.
  assign phase_good = $onehot(phase) &&
                      ((phase == prev_phase_reg) ||
                       (phase == {prev_phase_reg[0], prev_phase_reg[3:1]}));

  assign wrap_step = (state_reg == ST_RUN) && phase_good &&
                     (phase == PH_FIRST) && (prev_phase_reg == PH_LAST);

  // Outside RUN nothing is being scanned, so pending data can land right away.
  assign xfer = shadow_pending_reg &&
                ((state_reg == ST_SYNC) || (state_reg == ST_FAULT) || wrap_step);

  assign disp_data = xfer ? shadow_reg : active_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit_sel
      assign sel_nib[gi] = phase[3-gi] ? disp_data[15-4*gi -: 4] : 4'h0;
    end
  endgenerate

  assign nibble       = sel_nib[0] | sel_nib[1] | sel_nib[2] | sel_nib[3];
  assign seg_next     = decode(nibble);
  assign bad_cnt_next = bad_cnt_reg + 4'd1;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg          <= ST_SYNC;
      an_reg             <= 4'b0000;
      seg_reg            <= 7'b0000000;
      rotations_reg      <= 8'd0;
      fault_reg          <= 1'b0;
      active_reg         <= 16'h0000;
      shadow_reg         <= 16'h0000;
      shadow_pending_reg <= 1'b0;
      bad_cnt_reg        <= 4'd0;
      prev_phase_reg     <= 4'b0000;
    end else begin
      if (xfer) begin
        active_reg         <= shadow_reg;
        shadow_pending_reg <= 1'b0;
      end
      if (accept) begin
        shadow_reg         <= wr.wr_data;
        shadow_pending_reg <= 1'b1;
      end

      case (state_reg)
        ST_SYNC: begin
          if (phase == PH_FIRST) begin
            state_reg      <= ST_RUN;
            an_reg         <= phase;
            seg_reg        <= seg_next;
            prev_phase_reg <= PH_FIRST;
            bad_cnt_reg    <= 4'd0;
          end else begin
            an_reg  <= 4'b0000;
            seg_reg <= 7'b0000000;
          end
        end

        ST_RUN: begin
          if (phase_good) begin
            an_reg         <= phase;
            seg_reg        <= seg_next;
            bad_cnt_reg    <= 4'd0;
            prev_phase_reg <= phase;
            if (wrap_step) begin
              rotations_reg <= rotations_reg + 8'd1;
            end
          end else begin
            an_reg      <= 4'b0000;
            seg_reg     <= 7'b0000000;
            bad_cnt_reg <= bad_cnt_next;
            if (bad_cnt_next == BAD_LIMIT) begin
              state_reg <= ST_FAULT;
              fault_reg <= 1'b1;
            end
          end
        end

        ST_FAULT: begin
          an_reg  <= 4'b0000;
          seg_reg <= 7'b0000000;
          if (fault_clr) begin
            state_reg   <= ST_SYNC;
            bad_cnt_reg <= 4'd0;
            fault_reg   <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_SYNC;
          an_reg    <= 4'b0000;
          seg_reg   <= 7'b0000000;
        end
      endcase
    end
  end

  assign an        = SEG_ACTIVE_LOW ? ~an_reg  : an_reg;
  assign seg       = SEG_ACTIVE_LOW ? ~seg_reg : seg_reg;
  assign rotations = rotations_reg;
  assign fault     = fault_reg;

endmodule
